neureka_descale: RTL and testbench

Return-path counterpart of the NEUREKA input scaler: accepts signed OUT_ACC-bit accumulator beats on an HWPE stream, applies an arithmetic right shift with optional round-to-nearest, optional ReLU, and saturates to INP_ACC bits. It is a 2-stage elastic pipeline at full throughput between the accumulator readout and the output streamer. It also counts saturated beats for debug and quantization tuning.

---
 rtl/neureka_descale.sv | 137 +++++++++++++
 tb/tb_neureka_descale.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/neureka_descale.sv
// neureka_descale: 2-stage elastic descaler (arithmetic shift, optional rounding,
// optional ReLU, saturation to INP_ACC bits). Define NEUREKA_DESCALE_SATCNT_EN to build the saturation counter.
module neureka_descale #(
  parameter int unsigned INP_ACC  = 8,
  parameter int unsigned OUT_ACC  = 16,
  parameter int unsigned N_SHIFTS = 8,
  localparam int unsigned SHW     = (N_SHIFTS > 1) ? $clog2(N_SHIFTS) : 1,
  localparam int unsigned STRB_I  = (OUT_ACC + 7) / 8,
  localparam int unsigned STRB_O  = (INP_ACC + 7) / 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               test_mode_i,
  input  logic               clear_i,
  input  logic               data_i_valid,
  output logic               data_i_ready,
  input  logic [OUT_ACC-1:0] data_i_data,
  input  logic [STRB_I-1:0]  data_i_strb,
  output logic               data_o_valid,
  input  logic               data_o_ready,
  output logic [INP_ACC-1:0] data_o_data,
  output logic [STRB_O-1:0]  data_o_strb,
  input  logic [SHW-1:0]     ctrl_i_shift_sel,
  input  logic               ctrl_i_round_en,
  input  logic               ctrl_i_relu,
  output logic [15:0]        flags_o_sat_cnt,
  output logic               flags_o_busy
);

  localparam logic signed [OUT_ACC:0] C_SMAX = (OUT_ACC+1)'((2 ** (INP_ACC - 1)) - 1);
  localparam logic signed [OUT_ACC:0] C_SMIN = -C_SMAX - (OUT_ACC+1)'(1);
  localparam logic signed [OUT_ACC:0] C_UMAX = (OUT_ACC+1)'((2 ** INP_ACC) - 1);

  logic                      r_v1, r_v2, r_relu1;
  logic signed [OUT_ACC:0]   r_x1;
  logic [INP_ACC-1:0]        r_q2;
  logic                      w_en1, w_en2, w_accept, w_adv2;
  logic signed [OUT_ACC:0]   w_x, w_rnd, w_sum, w_shifted;
  logic [INP_ACC-1:0]        w_q;
  logic                      w_sat;

  assign w_en2        = !r_v2 || data_o_ready;
  assign w_en1        = !r_v1 || w_en2;
  assign data_i_ready = w_en1 && !clear_i;
  assign w_accept     = data_i_valid && data_i_ready;
  assign w_adv2       = w_en2 && r_v1;

  assign data_o_valid = r_v2;
  assign data_o_data  = r_q2;
  assign data_o_strb  = '1;
  assign flags_o_busy = r_v1 || r_v2;

  // One extra bit of headroom absorbs the rounding carry out of the accumulator range.
  always_comb begin
    w_x = $signed({data_i_data[OUT_ACC-1], data_i_data});
    w_rnd = '0;
    if (ctrl_i_round_en && (ctrl_i_shift_sel != '0))
      w_rnd = $signed((OUT_ACC+1)'(1) << (ctrl_i_shift_sel - SHW'(1)));
    w_sum     = w_x + w_rnd;
    w_shifted = w_sum >>> ctrl_i_shift_sel;
  end

  // Negative values clamped to zero under ReLU are not counted as saturation.
  always_comb begin
    w_q   = r_x1[INP_ACC-1:0];
    w_sat = 1'b0;
    if (r_relu1) begin
      if (r_x1 < 0) begin
        w_q = '0;
      end else if (r_x1 > C_UMAX) begin
        w_q   = '1;
        w_sat = 1'b1;
      end
    end else begin
      if (r_x1 > C_SMAX) begin
        w_q   = C_SMAX[INP_ACC-1:0];
        w_sat = 1'b1;
      end else if (r_x1 < C_SMIN) begin
        w_q   = C_SMIN[INP_ACC-1:0];
        w_sat = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_relu1 <= 1'b0;
      r_x1    <= '0;
      r_q2    <= '0;
    end else if (clear_i) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else begin
      if (w_en1)
        r_v1 <= w_accept;
      if (w_accept) begin
        r_x1    <= w_shifted;
        r_relu1 <= ctrl_i_relu;
      end
      if (w_en2)
        r_v2 <= r_v1;
      if (w_adv2)
        r_q2 <= w_q;
    end
  end

`ifdef NEUREKA_DESCALE_SATCNT_EN
  logic        r_sat2;
  logic [15:0] r_sat_cnt;
  logic        w_unused;

  assign w_unused        = ^{test_mode_i, data_i_strb};
  assign flags_o_sat_cnt = r_sat_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_sat2    <= 1'b0;
      r_sat_cnt <= '0;
    end else if (clear_i) begin
      r_sat_cnt <= '0;
    end else begin
      if (w_adv2)
        r_sat2 <= w_sat;
      if (data_o_valid && data_o_ready && r_sat2 && (r_sat_cnt != '1))
        r_sat_cnt <= r_sat_cnt + 16'd1;
    end
  end
`else
  logic w_unused;

  assign w_unused        = ^{test_mode_i, data_i_strb, w_sat};
  assign flags_o_sat_cnt = '0;
`endif

endmodule

// File: tb/tb_neureka_descale.sv
// Scoreboard bench for neureka_descale: integer reference model feeds an expectation
// queue; a negedge monitor compares every presented output beat and the saturation counter.
module tb_neureka_descale;

  typedef struct {
    logic [7:0] d;
    bit         sat;
  } exp_t;

  localparam int RDY_HIGH = 0;
  localparam int RDY_LOW  = 1;
  localparam int RDY_RAND = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        test_mode = 1'b0;
  logic        clear = 1'b0;
  logic        iv = 1'b0;
  logic        ir;
  logic [15:0] idata = '0;
  logic [1:0]  istrb = 2'b11;
  logic        ov;
  logic        ordy;
  logic [7:0]  odata;
  logic [0:0]  ostrb;
  logic [2:0]  shs = '0;
  logic        rnd = 1'b0;
  logic        relu = 1'b0;
  logic [15:0] sat_cnt;
  logic        busy;

  int   rdy_mode = RDY_HIGH;
  logic rnd_rdy = 1'b1;
  bit   mon_en = 1'b0;
  int   flush_gen = 0;
  int   flush_seen = 0;
  int   m_cnt = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q[$];

  assign ordy = (rdy_mode == RDY_RAND) ? rnd_rdy : (rdy_mode == RDY_HIGH);

  neureka_descale #(.INP_ACC(8), .OUT_ACC(16), .N_SHIFTS(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .test_mode_i(test_mode), .clear_i(clear),
    .data_i_valid(iv), .data_i_ready(ir), .data_i_data(idata), .data_i_strb(istrb),
    .data_o_valid(ov), .data_o_ready(ordy), .data_o_data(odata), .data_o_strb(ostrb),
    .ctrl_i_shift_sel(shs), .ctrl_i_round_en(rnd), .ctrl_i_relu(relu),
    .flags_o_sat_cnt(sat_cnt), .flags_o_busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rnd_rdy = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sc(input int n);
`ifdef NEUREKA_DESCALE_SATCNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  // Reference: round-half-up then floor division by 2^s, then clamp.
  function automatic exp_t model(input int x, input int s, input bit r, input bit rl);
    int   v, d, m;
    exp_t e;
    v = x;
    d = 1 << s;
    if (r && s > 0) v = v + d / 2;
    m = v % d;
    if (m < 0) m = m + d;
    v = (v - m) / d;
    e.sat = 1'b0;
    if (rl) begin
      if (v < 0) v = 0;
      else if (v > 255) begin v = 255; e.sat = 1'b1; end
    end else begin
      if (v > 127) begin v = 127; e.sat = 1'b1; end
      else if (v < -128) begin v = -128; e.sat = 1'b1; end
    end
    e.d = v[7:0];
    return e;
  endfunction

  task automatic send(input logic [15:0] x, input int s, input bit r, input bit rl, output int waited);
    iv = 1'b1; idata = x; shs = s[2:0]; rnd = r; relu = rl;
    waited = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (ir) break;
      waited++;
    end
    if (!ir) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: got ready=0 expected ready=1 within 200 cycles");
      $fatal(1, "input never accepted");
    end
    q.push_back(model(int'($signed(x)), s, r, rl));
    @(posedge clk); #1;
    iv = 1'b0;
  endtask

  task automatic drain();
    rdy_mode = RDY_HIGH;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    #1;
    chk("drain_idle", {31'd0, busy}, 32'd0);
    chk("drain_queue", q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin : monitor
    exp_t e;
    wait (mon_en);
    forever begin
      @(negedge clk);
      chk("sat_cnt", {16'd0, sat_cnt}, sc(m_cnt));
      if (ov) begin
        if (q.size() == 0) begin
          chk("unexpected_output", {31'd0, ov}, 32'd0);
        end else begin
          chk("data", {24'd0, odata}, {24'd0, q[0].d});
          if (ordy) begin
            e = q.pop_front();
            if (e.sat && m_cnt < 16'hFFFF) m_cnt++;
          end
        end
      end
      if (flush_seen != flush_gen) begin
        q.delete();
        m_cnt = 0;
        flush_seen = flush_gen;
      end
    end
  end

  initial begin : stim
    int w, tot;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, ov}, 32'd0);
    chk("rst_data", {24'd0, odata}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_satcnt", {16'd0, sat_cnt}, 32'd0);
    chk("strb", {31'd0, ostrb}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Rounding and latency
    send(16'h0190, 2, 1'b1, 1'b0, w);
    @(negedge clk);
    chk("latency_edge1", {31'd0, ov}, 32'd0);
    @(negedge clk);
    chk("latency_edge2", {31'd0, ov}, 32'd1);
    @(posedge clk); #1;
    send(16'hFFFD, 1, 1'b1, 1'b0, w);
    send(16'hFFFD, 1, 1'b0, 1'b0, w);
    send(16'h7FFF, 0, 1'b0, 1'b0, w);
    send(16'h8000, 0, 1'b0, 1'b0, w);
    send(16'h7FFF, 1, 1'b1, 1'b0, w);
    drain();
    chk("satcnt_after_sat", {16'd0, sat_cnt}, sc(3));

    // ReLU
    send(16'hFFCE, 0, 1'b0, 1'b1, w);
    send(16'd300, 0, 1'b0, 1'b1, w);
    send(16'd200, 0, 1'b0, 1'b1, w);
    drain();
    chk("satcnt_after_relu", {16'd0, sat_cnt}, sc(4));

    // Backpressure fills both stages
    rdy_mode = RDY_LOW;
    send(16'd1, 0, 1'b0, 1'b0, w);
    send(16'd2, 0, 1'b0, 1'b0, w);
    @(negedge clk);
    chk("full_ready", {31'd0, ir}, 32'd0);
    chk("full_busy", {31'd0, busy}, 32'd1);
    chk("full_head", {24'd0, odata}, 32'd1);
    @(posedge clk); #1;
    rdy_mode = RDY_HIGH;
    send(16'd3, 0, 1'b0, 1'b0, w);
    send(16'd4, 0, 1'b0, 1'b0, w);
    drain();

    // Per-beat control at full rate
    tot = 0;
    for (int i = 0; i < 4; i++) begin
      send(16'h0040, (i % 2 == 0) ? 0 : 3, 1'b0, 1'b0, w);
      tot += w;
    end
    chk("full_rate_stalls", tot, 32'd0);
    drain();

    // Random traffic with random backpressure
    rdy_mode = RDY_RAND;
    for (int i = 0; i < 300; i++) begin
      send(16'($urandom), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), w);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    drain();

    // Clear mid-stream
    clear = 1'b1; flush_gen++;
    @(posedge clk); #1;
    clear = 1'b0;
    for (int i = 0; i < 5; i++) send(16'h7FFF, 0, 1'b0, 1'b0, w);
    drain();
    chk("satcnt_five", {16'd0, sat_cnt}, sc(5));
    rdy_mode = RDY_LOW;
    send(16'h0011, 0, 1'b0, 1'b0, w);
    send(16'h0022, 0, 1'b0, 1'b0, w);
    clear = 1'b1; iv = 1'b1; idata = 16'h0033; flush_gen++;
    @(negedge clk);
    chk("clear_ready", {31'd0, ir}, 32'd0);
    @(posedge clk); #1;
    clear = 1'b0; iv = 1'b0;
    @(negedge clk);
    chk("clear_valid", {31'd0, ov}, 32'd0);
    chk("clear_busy", {31'd0, busy}, 32'd0);
    chk("clear_satcnt", {16'd0, sat_cnt}, 32'd0);
    @(posedge clk); #1;
    rdy_mode = RDY_HIGH;
    repeat (5) @(negedge clk);
    chk("clear_no_leak", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;

    // Reset mid-stream
    send(16'h8000, 0, 1'b0, 1'b0, w);
    send(16'h7FFF, 0, 1'b0, 1'b0, w);
    drain();
    rdy_mode = RDY_LOW;
    send(16'h0044, 0, 1'b0, 1'b0, w);
    send(16'h0055, 0, 1'b0, 1'b0, w);
    rst_n = 1'b0; iv = 1'b1; idata = 16'h0066; flush_gen++;
    @(posedge clk); #1;
    rst_n = 1'b1; iv = 1'b0;
    @(negedge clk);
    chk("reset_valid", {31'd0, ov}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_satcnt", {16'd0, sat_cnt}, 32'd0);
    chk("reset_data", {24'd0, odata}, 32'd0);
    @(posedge clk); #1;
    rdy_mode = RDY_HIGH;
    send(16'h0190, 2, 1'b1, 1'b0, w);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
